// File: rtl/ili9341_seq_ctrl_pkg.sv
// ili9341_seq_ctrl_pkg: shared types and ILI9341 command constants for the panel sequencer.
package ili9341_seq_ctrl_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_HW_RST, S_RST_WAIT, S_FETCH, S_SEND, S_WAIT_DONE, S_DLY, S_READY
    } state_t;
    typedef enum logic [1:0] {K_CMD = 2'b00, K_DATA = 2'b01, K_DELAY = 2'b10, K_END = 2'b11} rom_kind_t;
    typedef enum logic [1:0] {PH_INIT, PH_RAMWR, PH_HI, PH_LO} phase_t;
    localparam logic [7:0] SWRESET = 8'h01;
    localparam logic [7:0] SLPOUT  = 8'h11;
    localparam logic [7:0] DISPON  = 8'h29;
    localparam logic [7:0] CASET   = 8'h2A;
    localparam logic [7:0] PASET   = 8'h2B;
    localparam logic [7:0] RAMWR   = 8'h2C;
    localparam logic [7:0] MADCTL  = 8'h36;
    localparam logic [7:0] COLMOD  = 8'h3A;
    function automatic logic [9:0] ent(rom_kind_t k, logic [7:0] v);
        return {k, v};
    endfunction
endpackage

// File: rtl/ili9341_seq_ctrl_init_rom.sv
// ili9341_seq_ctrl_init_rom: combinational init command table, index -> {kind, value}.
module ili9341_seq_ctrl_init_rom
    import ili9341_seq_ctrl_pkg::*;
#(
    parameter int ROM_DEPTH = 32,
    localparam int AW = $clog2(ROM_DEPTH)
) (
    input  logic [AW-1:0] idx_i,
    output logic [9:0]    entry_o
);
    // Window is the full 240x320 panel; the table ends by opening RAMWR for pixels.
    always_comb begin
        case (int'(idx_i))
            0:       entry_o = ent(K_CMD, SWRESET);
            1:       entry_o = ent(K_DELAY, 8'd5);
            2:       entry_o = ent(K_CMD, SLPOUT);
            3:       entry_o = ent(K_DELAY, 8'd0);
            4:       entry_o = ent(K_CMD, COLMOD);
            5:       entry_o = ent(K_DATA, 8'h55);
            6:       entry_o = ent(K_CMD, MADCTL);
            7:       entry_o = ent(K_DATA, 8'h48);
            8:       entry_o = ent(K_CMD, DISPON);
            9:       entry_o = ent(K_CMD, CASET);
            10:      entry_o = ent(K_DATA, 8'h00);
            11:      entry_o = ent(K_DATA, 8'h00);
            12:      entry_o = ent(K_DATA, 8'h00);
            13:      entry_o = ent(K_DATA, 8'hEF);
            14:      entry_o = ent(K_CMD, PASET);
            15:      entry_o = ent(K_DATA, 8'h00);
            16:      entry_o = ent(K_DATA, 8'h00);
            17:      entry_o = ent(K_DATA, 8'h01);
            18:      entry_o = ent(K_DATA, 8'h3F);
            19:      entry_o = ent(K_CMD, RAMWR);
            default: entry_o = ent(K_END, 8'h00);
        endcase
    end
endmodule

// File: rtl/ili9341_seq_ctrl.sv
// ili9341_seq_ctrl: panel reset, init ROM playback and RGB565 pixel streaming over a SPI byte engine.
module ili9341_seq_ctrl
    import ili9341_seq_ctrl_pkg::*;
#(
    parameter int RST_LOW_CYC  = 1000,
    parameter int RST_WAIT_CYC = 120000,
    parameter int DELAY_UNIT   = 1000,
    parameter int ROM_DEPTH    = 32,
    parameter int FRAME_PIX    = 76800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    output logic        spi_send,
    output logic [7:0]  spi_byte,
    input  logic        spi_done,
    output logic        lcd_dc,
    output logic        lcd_cs_n,
    output logic        lcd_rst_n,
    output logic        init_done,
    output logic        busy
);
    localparam int AW = $clog2(ROM_DEPTH);
    localparam int PW = $clog2(FRAME_PIX + 1);

    state_t          state_q, state_d;
    phase_t          phase_q, phase_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [PW-1:0]   pix_cnt_q, pix_cnt_d;
    logic [15:0]     pix_q, pix_d;
    logic [7:0]      byte_q, byte_d;
    logic            dc_q, dc_d, cs_q, cs_d, init_q, init_d;
    logic [9:0]      entry;
    rom_kind_t       kind;
    logic [7:0]      val;
    logic            rom_end, wrap;

    ili9341_seq_ctrl_init_rom #(.ROM_DEPTH(ROM_DEPTH)) u_rom (.idx_i(idx_q), .entry_o(entry));

    assign kind    = rom_kind_t'(entry[9:8]);
    assign val     = entry[7:0];
    assign rom_end = kind == K_END || idx_q == AW'(ROM_DEPTH - 1);
    // Count saturates at FRAME_PIX so the next accepted pixel knows to reopen RAMWR.
    assign wrap    = pix_cnt_q == PW'(FRAME_PIX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            phase_q   <= PH_INIT;
            cnt_q     <= '0;
            idx_q     <= '0;
            pix_cnt_q <= '0;
            pix_q     <= '0;
            byte_q    <= '0;
            dc_q      <= 1'b0;
            cs_q      <= 1'b0;
            init_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pix_cnt_q <= pix_cnt_d;
            pix_q     <= pix_d;
            byte_q    <= byte_d;
            dc_q      <= dc_d;
            cs_q      <= cs_d;
            init_q    <= init_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        pix_cnt_d = pix_cnt_q;
        pix_d     = pix_q;
        byte_d    = byte_q;
        dc_d      = dc_q;
        cs_d      = cs_q;
        init_d    = init_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_HW_RST;
                cnt_d   = 32'(RST_LOW_CYC - 1);
                init_d  = 1'b0;
            end
            S_HW_RST: if (cnt_q == '0) begin
                state_d = S_RST_WAIT;
                cnt_d   = 32'(RST_WAIT_CYC - 1);
            end else cnt_d = cnt_q - 32'd1;
            S_RST_WAIT: if (cnt_q == '0) begin
                state_d = S_FETCH;
                idx_d   = '0;
            end else cnt_d = cnt_q - 32'd1;
            S_FETCH: if (rom_end) begin
                state_d = S_READY;
                init_d  = 1'b1;
            end else if (kind == K_DELAY) begin
                if (val == '0) idx_d = idx_q + 1'b1;
                else begin
                    state_d = S_DLY;
                    cnt_d   = 32'(int'(val) * DELAY_UNIT - 1);
                end
            end else begin
                state_d = S_SEND;
                phase_d = PH_INIT;
                byte_d  = val;
                dc_d    = kind == K_DATA;
            end
            S_SEND: begin
                state_d = S_WAIT_DONE;
                cs_d    = 1'b1;
            end
            S_WAIT_DONE: if (spi_done) begin
                case (phase_q)
                    PH_INIT: begin
                        state_d = S_FETCH;
                        idx_d   = idx_q + 1'b1;
                    end
                    PH_RAMWR: begin
                        state_d = S_SEND;
                        phase_d = PH_HI;
                        byte_d  = pix_q[15:8];
                        dc_d    = 1'b1;
                    end
                    PH_HI: begin
                        state_d = S_SEND;
                        phase_d = PH_LO;
                        byte_d  = pix_q[7:0];
                        dc_d    = 1'b1;
                    end
                    default: state_d = S_READY;
                endcase
            end
            S_DLY: if (cnt_q == '0) begin
                state_d = S_FETCH;
                idx_d   = idx_q + 1'b1;
            end else cnt_d = cnt_q - 32'd1;
            S_READY: if (pix_valid) begin
                state_d   = S_SEND;
                pix_d     = pix_data;
                pix_cnt_d = wrap ? PW'(1) : pix_cnt_q + 1'b1;
                phase_d   = wrap ? PH_RAMWR : PH_HI;
                byte_d    = wrap ? RAMWR : pix_data[15:8];
                dc_d      = !wrap;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        spi_send  = state_q == S_SEND;
        spi_byte  = byte_q;
        lcd_dc    = dc_q;
        lcd_cs_n  = !(cs_q || state_q == S_SEND);
        lcd_rst_n = !(state_q == S_IDLE || state_q == S_HW_RST);
        pix_ready = state_q == S_READY;
        init_done = init_q;
        busy      = state_q != S_IDLE;
    end
endmodule

// File: tb/tb_ili9341_seq_ctrl.sv
// tb_ili9341_seq_ctrl: bench for the ILI9341 sequencer with a 9-cycle byte engine and a timeline model.
module tb_ili9341_seq_ctrl;
    localparam int RL = 4;
    localparam int RW = 8;
    localparam int DU = 2;
    localparam int FP = 4;

    logic        clk, rst, start, pix_valid, pix_ready, spi_send, spi_done;
    logic        lcd_dc, lcd_cs_n, lcd_rst_n, init_done, busy, eng_done, spur;
    logic [15:0] pix_data;
    logic [7:0]  spi_byte;
    int          total, bad;

    assign spi_done = eng_done | spur;

    ili9341_seq_ctrl #(
        .RST_LOW_CYC(RL), .RST_WAIT_CYC(RW), .DELAY_UNIT(DU), .ROM_DEPTH(32), .FRAME_PIX(FP)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(pix_ready), .spi_send(spi_send), .spi_byte(spi_byte), .spi_done(spi_done),
        .lcd_dc(lcd_dc), .lcd_cs_n(lcd_cs_n), .lcd_rst_n(lcd_rst_n), .init_done(init_done),
        .busy(busy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected init stream: kind 0=cmd 1=data 2=delay 3=end.
    logic [1:0] rk [0:20] = '{0,2,0,2,0,1,0,1,0,0,1,1,1,1,0,1,1,1,1,0,3};
    logic [7:0] rv [0:20] = '{8'h01,8'd5,8'h11,8'd0,8'h3A,8'h55,8'h36,8'h48,8'h29,8'h2A,
                              8'h00,8'h00,8'h00,8'hEF,8'h2B,8'h00,8'h00,8'h01,8'h3F,8'h2C,8'h00};

    typedef struct packed {logic dc; logic [7:0] b;} xb_t;
    typedef struct {int cyc; logic dc; logic [7:0] b;} lg_t;
    xb_t q[$];
    lg_t lg[$];
    xb_t cur;
    int  cyc, next_send, ready_from, init_from, rel, rom_i, pc, eng_cnt, busy_rise, lo_cnt;
    bit  started, in_init, inflight, any_sent, cs_low, prev_busy, exp_send, exp_rdy;

    task automatic walk(input int t);
        while (rk[rom_i] == 2'd2) begin
            t += 1 + int'(rv[rom_i]) * DU;
            rom_i++;
        end
        if (rk[rom_i] == 2'd3) begin
            ready_from = t + 1;
            init_from  = t + 1;
            in_init    = 0;
        end else next_send = t + 1;
    endtask

    initial begin
        eng_done = 0; cyc = 0; busy_rise = -1; lo_cnt = 0; prev_busy = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                started = 0; in_init = 0; inflight = 0; any_sent = 0; cs_low = 0;
                next_send = -1; ready_from = -1; init_from = -1; rom_i = 0; pc = 0;
                eng_cnt = 0; eng_done = 0; q.delete();
            end
            exp_send = rst && cyc == next_send;
            if (exp_send) begin
                if (in_init) begin
                    cur.dc = rk[rom_i] == 2'd1;
                    cur.b  = rv[rom_i];
                end else cur = q.pop_front();
                inflight = 1; any_sent = 1; cs_low = 1; next_send = -1;
            end
            exp_rdy = ready_from >= 0 && cyc >= ready_from;
            chk("spi_send", spi_send, exp_send);
            chk("lcd_rst_n", lcd_rst_n, started && cyc >= rel);
            chk("lcd_cs_n", lcd_cs_n, !cs_low);
            chk("busy", busy, started);
            chk("pix_ready", pix_ready, exp_rdy);
            chk("init_done", init_done, init_from >= 0 && cyc >= init_from);
            if (inflight) begin
                chk("spi_byte", spi_byte, cur.b);
                chk("lcd_dc", lcd_dc, cur.dc);
            end else if (!any_sent) begin
                chk("spi_byte_rst", spi_byte, 0);
                chk("lcd_dc_rst", lcd_dc, 0);
            end
            if (spi_send) lg.push_back('{cyc, lcd_dc, spi_byte});
            if (busy && !prev_busy) busy_rise = cyc;
            if (busy && !lcd_rst_n) lo_cnt++;
            prev_busy = busy;
            if (rst) begin
                eng_done = 0;
                if (eng_cnt > 0) begin
                    eng_cnt--;
                    if (eng_cnt == 0) begin
                        eng_done = 1;
                        inflight = 0;
                        if (in_init) begin
                            rom_i++;
                            walk(cyc + 1);
                        end else if (q.size() > 0) next_send = cyc + 1;
                        else ready_from = cyc + 1;
                    end
                end else if (spi_send) eng_cnt = 9;
                if (exp_rdy && pix_valid) begin
                    if (pc == FP) begin
                        q.push_back({1'b0, 8'h2C});
                        pc = 1;
                    end else pc++;
                    q.push_back({1'b1, pix_data[15:8]});
                    q.push_back({1'b1, pix_data[7:0]});
                    next_send = cyc + 1;
                    ready_from = -1;
                end
                if (!started && start) begin
                    started = 1; in_init = 1; rom_i = 0;
                    rel = cyc + 1 + RL;
                    walk(cyc + 1 + RL + RW);
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #2 start = 1;
        @(posedge clk); #2 start = 0;
    endtask

    task automatic wait_init(input string nm);
        int n = 0;
        do begin @(negedge clk); n++; end while (!init_done && n < 2000);
        chk({nm, "_timeout"}, 32'(n < 2000), 1);
    endtask

    task automatic push_pix(input logic [15:0] d);
        int n = 0;
        @(posedge clk); #2 pix_valid = 1; pix_data = d;
        do begin @(negedge clk); n++; end while (!pix_ready && n < 200);
        @(posedge clk); #2 pix_valid = 0;
        chk("accept_timeout", 32'(n < 200), 1);
        n = 0;
        do begin @(negedge clk); n++; end while (!pix_ready && n < 200);
        chk("pixel_timeout", 32'(n < 200), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, base;
        total = 0; bad = 0;
        rst = 1; start = 0; pix_valid = 0; pix_data = '0; spur = 0;
        #1 rst = 0;
        repeat (3) @(negedge clk);
        chk("reset_cs_n", lcd_cs_n, 1);
        chk("reset_rst_n", lcd_rst_n, 0);
        @(posedge clk); #2 rst = 1;
        repeat (2) @(posedge clk);
        pulse_start();
        wait_init("init");
        chk("init_bytes", lg.size(), 18);
        chk("first_byte", lg[0].b, 8'h01);
        chk("first_dc", lg[0].dc, 0);
        chk("rst_low_cycles", lo_cnt, RL);
        chk("first_send_latency", lg[0].cyc - busy_rise, 13);
        chk("delay5_gap", lg[1].cyc - lg[0].cyc, 22);
        chk("last_init_byte", lg[17].b, 8'h2C);
        @(posedge clk); #2 start = 1; spur = 1;
        @(posedge clk); #2 start = 0; spur = 0;
        repeat (5) @(negedge clk);
        chk("ready_ignores_start", lg.size(), 18);
        chk("ready_hold", pix_ready, 1);
        push_pix(16'hF800);
        chk("pix1_hi", lg[18].b, 8'hF8);
        chk("pix1_lo", lg[19].b, 8'h00);
        chk("pix1_dc", {lg[18].dc, lg[19].dc}, 2'b11);
        push_pix(16'h07E0);
        push_pix(16'h001F);
        push_pix(16'h1234);
        push_pix(16'hABCD);
        chk("wrap_ramwr", lg[26].b, 8'h2C);
        chk("wrap_ramwr_dc", lg[26].dc, 0);
        chk("pix5_hi", lg[27].b, 8'hAB);
        chk("pix5_lo", lg[28].b, 8'hCD);
        @(posedge clk); #2 pix_valid = 1; pix_data = 16'h5555;
        n = 0;
        do begin @(negedge clk); n++; end while (!spi_send && n < 50);
        chk("abort_send_timeout", 32'(n < 50), 1);
        @(posedge clk); #2 pix_valid = 0;
        repeat (2) @(posedge clk);
        #2 rst = 0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_cs_n", lcd_cs_n, 1);
        chk("abort_send", spi_send, 0);
        @(posedge clk); #2 rst = 1;
        base = lg.size();
        pulse_start();
        wait_init("reinit");
        chk("reinit_first", lg[base].b, 8'h01);
        chk("reinit_count", lg.size() - base, 18);
        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
